// File: rtl/dma_transfer_engine.sv
// Single-descriptor DMA engine: moves data between a DRAM burst bus and the
// GLB SRAM port. Bursts never cross a 4 KB page and are capped at MAX_BURST.
module dma_transfer_engine #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned GLB_AW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [31:0]       desc_addr_i,
  input  logic [31:0]       desc_len_i,
  input  logic [GLB_AW-1:0] desc_glb_addr_i,
  input  logic              desc_dir_i,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic [31:0]       bus_req_addr_o,
  output logic [3:0]        bus_req_len_o,
  output logic              bus_req_write_o,
  input  logic              bus_rdata_valid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_rdata_last_i,
  output logic              bus_wdata_valid_o,
  input  logic              bus_wdata_ready_i,
  output logic [31:0]       bus_wdata_o,
  output logic [3:0]        bus_wstrb_o,
  output logic              bus_wlast_o,
  input  logic              bus_wresp_valid_i,
  output logic              glb_en_o,
  output logic              glb_we_o,
  output logic [GLB_AW-1:0] glb_addr_o,
  output logic [31:0]       glb_wdata_o,
  output logic [3:0]        glb_wstrb_o,
  input  logic [31:0]       glb_rdata_i,
  output logic              dma_interrupt_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP, DONE
  } state_t;

  state_t            state, state_next;
  logic [31:0]       addr;
  logic [GLB_AW-1:0] glb_ptr;
  logic [30:0]       remaining;
  logic [3:0]        tail_strb;
  logic [4:0]        burst_left;
  logic [4:0]        rd_left;
  logic [31:0]       fifo_mem [2];
  logic              fifo_head;
  logic [1:0]        fifo_cnt;
  logic              inflight;

  logic [10:0]       page_beats;
  logic [30:0]       lim;
  logic [4:0]        req_beats;
  logic [4:0]        req_len_m1;
  logic              last_desc_beat;
  logic              glb_rd;
  logic              wr_pop;
  logic              fifo_push;
  logic              fifo_pop;
  logic [3:0]        len_tail;

  // bus_rdata_last_i is informational; beat counting decides burst end
  logic unused;
  assign unused = ^{bus_rdata_last_i, desc_addr_i[1:0]};

  // Burst size: min of cap, remaining beats, and beats left in the 4 KB page
  always_comb begin
    page_beats = 11'd1024 - {1'b0, addr[11:2]};
    lim        = 31'(MAX_BURST);
    if (remaining < lim) lim = remaining;
    if ({20'd0, page_beats} < lim) lim = {20'd0, page_beats};
    req_beats  = lim[4:0];
    req_len_m1 = req_beats - 5'd1;
  end

  // Strobe for the final beat of a descriptor
  always_comb begin
    case (desc_len_i[1:0])
      2'd1:    len_tail = 4'b0001;
      2'd2:    len_tail = 4'b0011;
      2'd3:    len_tail = 4'b0111;
      default: len_tail = 4'b1111;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and output decode
  always_comb begin
    state_next        = state;
    desc_ready_o      = 1'b0;
    busy_o            = 1'b1;
    bus_req_valid_o   = 1'b0;
    bus_req_addr_o    = '0;
    bus_req_len_o     = '0;
    bus_req_write_o   = 1'b0;
    bus_wdata_valid_o = 1'b0;
    bus_wdata_o       = '0;
    bus_wstrb_o       = '0;
    bus_wlast_o       = 1'b0;
    glb_en_o          = 1'b0;
    glb_we_o          = 1'b0;
    glb_addr_o        = '0;
    glb_wdata_o       = '0;
    glb_wstrb_o       = '0;
    dma_interrupt_o   = 1'b0;
    glb_rd            = 1'b0;
    wr_pop            = 1'b0;
    last_desc_beat    = (remaining == '0) && (burst_left == 5'd1);
    case (state)
      IDLE: begin
        desc_ready_o = 1'b1;
        busy_o       = 1'b0;
        if (desc_valid_i) begin
          if (desc_len_i == '0) state_next = DONE;
          else                  state_next = desc_dir_i ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        bus_req_valid_o = 1'b1;
        bus_req_addr_o  = addr;
        bus_req_len_o   = req_len_m1[3:0];
        bus_req_write_o = (state == WR_REQ);
        if (bus_req_ready_i) state_next = (state == WR_REQ) ? WR_DATA : RD_DATA;
      end
      RD_DATA: begin
        if (bus_rdata_valid_i) begin
          glb_en_o    = 1'b1;
          glb_we_o    = 1'b1;
          glb_addr_o  = glb_ptr;
          glb_wdata_o = bus_rdata_i;
          glb_wstrb_o = last_desc_beat ? tail_strb : 4'hF;
          if (burst_left == 5'd1) state_next = (remaining == '0) ? DONE : RD_REQ;
        end
      end
      WR_DATA: begin
        if (({1'b0, fifo_cnt} + {2'b00, inflight} < 3'd2) && (rd_left != '0)) begin
          glb_rd     = 1'b1;
          glb_en_o   = 1'b1;
          glb_addr_o = glb_ptr;
        end
        // Read data arriving this cycle bypasses an empty FIFO
        if ((fifo_cnt != '0) || inflight) begin
          bus_wdata_valid_o = 1'b1;
          bus_wdata_o       = (fifo_cnt != '0) ? fifo_mem[fifo_head] : glb_rdata_i;
          bus_wstrb_o       = last_desc_beat ? tail_strb : 4'hF;
          bus_wlast_o       = (burst_left == 5'd1);
        end
        wr_pop = bus_wdata_valid_o && bus_wdata_ready_i;
        if (wr_pop && (burst_left == 5'd1)) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (bus_wresp_valid_i) state_next = (remaining == '0) ? DONE : WR_REQ;
      end
      DONE: begin
        dma_interrupt_o = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Descriptor, address, pointer and beat counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      glb_ptr    <= '0;
      remaining  <= '0;
      tail_strb  <= '0;
      burst_left <= '0;
      rd_left    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (desc_valid_i) begin
            addr      <= {desc_addr_i[31:2], 2'b00};
            glb_ptr   <= desc_glb_addr_i;
            remaining <= {1'b0, desc_len_i[31:2]} + {30'd0, |desc_len_i[1:0]};
            tail_strb <= len_tail;
          end
        end
        RD_REQ, WR_REQ: begin
          if (bus_req_ready_i) begin
            addr       <= addr + {25'd0, req_beats, 2'b00};
            remaining  <= remaining - {26'd0, req_beats};
            burst_left <= req_beats;
            rd_left    <= req_beats;
          end
        end
        RD_DATA: begin
          if (bus_rdata_valid_i) begin
            glb_ptr    <= glb_ptr + GLB_AW'(1);
            burst_left <= burst_left - 5'd1;
          end
        end
        WR_DATA: begin
          if (glb_rd) begin
            glb_ptr <= glb_ptr + GLB_AW'(1);
            rd_left <= rd_left - 5'd1;
          end
          if (wr_pop) burst_left <= burst_left - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_push = inflight && !(wr_pop && (fifo_cnt == '0));
  assign fifo_pop  = wr_pop && (fifo_cnt != '0);

  // Two-entry write prefetch FIFO fed by one-cycle GLB reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      fifo_head <= 1'b0;
      fifo_cnt  <= '0;
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= glb_rd;
      if (fifo_push) fifo_mem[fifo_head ^ fifo_cnt[0]] <= glb_rdata_i;
      if (fifo_pop)  fifo_head <= ~fifo_head;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_transfer_engine.sv
// Directed plus randomized bench for dma_transfer_engine with a page/burst
// reference model and a GLB memory model.
module tb_dma_transfer_engine;
  localparam int unsigned MB = 16;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          desc_valid_i;
  logic          desc_ready_o;
  logic [31:0]   desc_addr_i;
  logic [31:0]   desc_len_i;
  logic [AW-1:0] desc_glb_addr_i;
  logic          desc_dir_i;
  logic          bus_req_valid_o;
  logic          bus_req_ready_i;
  logic [31:0]   bus_req_addr_o;
  logic [3:0]    bus_req_len_o;
  logic          bus_req_write_o;
  logic          bus_rdata_valid_i;
  logic [31:0]   bus_rdata_i;
  logic          bus_rdata_last_i;
  logic          bus_wdata_valid_o;
  logic          bus_wdata_ready_i;
  logic [31:0]   bus_wdata_o;
  logic [3:0]    bus_wstrb_o;
  logic          bus_wlast_o;
  logic          bus_wresp_valid_i;
  logic          glb_en_o;
  logic          glb_we_o;
  logic [AW-1:0] glb_addr_o;
  logic [31:0]   glb_wdata_o;
  logic [3:0]    glb_wstrb_o;
  logic [31:0]   glb_rdata_i;
  logic          dma_interrupt_o;
  logic          busy_o;

  dma_transfer_engine #(.MAX_BURST(MB), .GLB_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_addr_i(desc_addr_i), .desc_len_i(desc_len_i),
    .desc_glb_addr_i(desc_glb_addr_i), .desc_dir_i(desc_dir_i),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_req_addr_o(bus_req_addr_o), .bus_req_len_o(bus_req_len_o),
    .bus_req_write_o(bus_req_write_o),
    .bus_rdata_valid_i(bus_rdata_valid_i), .bus_rdata_i(bus_rdata_i),
    .bus_rdata_last_i(bus_rdata_last_i),
    .bus_wdata_valid_o(bus_wdata_valid_o), .bus_wdata_ready_i(bus_wdata_ready_i),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o), .bus_wlast_o(bus_wlast_o),
    .bus_wresp_valid_i(bus_wresp_valid_i),
    .glb_en_o(glb_en_o), .glb_we_o(glb_we_o), .glb_addr_o(glb_addr_o),
    .glb_wdata_o(glb_wdata_o), .glb_wstrb_o(glb_wstrb_o), .glb_rdata_i(glb_rdata_i),
    .dma_interrupt_o(dma_interrupt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // GLB SRAM model: read data one cycle after a read enable
  logic [31:0] gmem [0:(1<<AW)-1];
  always @(posedge clk) if (glb_en_o && !glb_we_o) glb_rdata_i <= gmem[glb_addr_o];

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference burst plan for the current descriptor
  longint unsigned ref_addr[$];
  longint unsigned ref_beats[$];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic plan(input logic [31:0] a, input logic [31:0] len);
    longint unsigned cur, left, room, b;
    ref_addr.delete();
    ref_beats.delete();
    cur  = longint'(a & 32'hFFFF_FFFC);
    left = (longint'(len) + 3) / 4;
    while (left > 0) begin
      room = (4096 - (cur % 4096)) / 4;
      b = MB;
      if (left < b) b = left;
      if (room < b) b = room;
      ref_addr.push_back(cur);
      ref_beats.push_back(b);
      cur  = cur + 4 * b;
      left = left - b;
    end
  endtask

  function automatic logic [3:0] ref_strb(input int unsigned len, input int unsigned beat);
    int unsigned nb;
    nb = (len + 3) / 4;
    if ((beat == nb - 1) && (len % 4 != 0)) return 4'((1 << (len % 4)) - 1);
    return 4'hF;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(desc_ready_o), 1);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_irq"}, 32'(dma_interrupt_o), 0);
    chk({tag, "_req"}, {bus_req_valid_o, bus_req_write_o, bus_req_len_o}, 0);
    chk({tag, "_req_addr"}, bus_req_addr_o, 0);
    chk({tag, "_wbeat"}, {bus_wdata_valid_o, bus_wlast_o, bus_wstrb_o}, 0);
    chk({tag, "_wdata"}, bus_wdata_o, 0);
    chk({tag, "_glb_ctl"}, {glb_en_o, glb_we_o, glb_wstrb_o}, 0);
    chk({tag, "_glb_addr"}, 32'(glb_addr_o), 0);
    chk({tag, "_glb_wdata"}, glb_wdata_o, 0);
  endtask

  task automatic send_desc(input logic [31:0] a, input logic [31:0] len,
                           input logic [AW-1:0] g, input logic dir);
    desc_valid_i = 1'b1;
    desc_addr_i = a;
    desc_len_i = len;
    desc_glb_addr_i = g;
    desc_dir_i = dir;
    #1;
    chk("desc_ready", 32'(desc_ready_o), 1);
    @(negedge clk);
    desc_valid_i = 1'b0;
    desc_addr_i = $urandom;
    desc_len_i = $urandom;
    desc_glb_addr_i = AW'($urandom);
    desc_dir_i = 1'($urandom);
  endtask

  task automatic req_phase(input string tag, input longint unsigned a,
                           input longint unsigned b, input logic wr);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 0;
    while (!acc) begin
      bus_req_ready_i = (n >= 3) ? 1'b1 : 1'($urandom);
      #1;
      chk({tag, "_req_valid"}, 32'(bus_req_valid_o), 1);
      chk({tag, "_req_addr"}, bus_req_addr_o, 32'(a));
      chk({tag, "_req_len"}, 32'(bus_req_len_o), 32'(b - 1));
      chk({tag, "_req_write"}, 32'(bus_req_write_o), 32'(wr));
      acc = bus_req_ready_i;
      @(negedge clk);
      n++;
      if (!bus_req_valid_o) acc = 1;
    end
    bus_req_ready_i = 1'b0;
  endtask

  task automatic zero_done();
    #1;
    chk("zero_irq", 32'(dma_interrupt_o), 1);
    chk("zero_req", 32'(bus_req_valid_o), 0);
    chk("zero_glb", 32'(glb_en_o), 0);
    @(negedge clk);
    #1;
    chk("zero_irq_off", 32'(dma_interrupt_o), 0);
    chk("zero_ready", 32'(desc_ready_o), 1);
    chk("zero_req2", 32'(bus_req_valid_o), 0);
    @(negedge clk);
  endtask

  task automatic finish_done(input string tag);
    #1;
    chk({tag, "_irq"}, 32'(dma_interrupt_o), 1);
    chk({tag, "_irq_req"}, 32'(bus_req_valid_o), 0);
    chk({tag, "_irq_ready"}, 32'(desc_ready_o), 0);
    @(negedge clk);
    #1;
    chk({tag, "_irq_off"}, 32'(dma_interrupt_o), 0);
    chk({tag, "_ready_back"}, 32'(desc_ready_o), 1);
    chk({tag, "_busy_off"}, 32'(busy_o), 0);
    @(negedge clk);
  endtask

  task automatic run_read(input logic [31:0] a, input logic [31:0] len, input logic [AW-1:0] g);
    int unsigned idx, waits;
    bit got;
    logic [31:0] d;
    plan(a, len);
    send_desc(a, len, g, 1'b0);
    if (ref_beats.size() == 0) begin
      zero_done();
      return;
    end
    idx = 0;
    for (int k = 0; k < ref_beats.size(); k++) begin
      req_phase("rd", ref_addr[k], ref_beats[k], 1'b0);
      for (int i = 0; i < int'(ref_beats[k]); i++) begin
        waits = 0;
        got = 0;
        while (!got) begin
          bus_rdata_valid_i = (waits >= 2) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
          d = $urandom;
          bus_rdata_i = d;
          bus_rdata_last_i = (i == int'(ref_beats[k]) - 1);
          #1;
          if (bus_rdata_valid_i) begin
            chk("rd_glb_en_we", {glb_en_o, glb_we_o}, 2'b11);
            chk("rd_glb_addr", 32'(glb_addr_o), 32'(AW'(g + idx)));
            chk("rd_glb_wdata", glb_wdata_o, d);
            chk("rd_glb_wstrb", 32'(glb_wstrb_o), 32'(ref_strb(len, idx)));
            got = 1;
            idx++;
          end else begin
            chk("rd_glb_idle", 32'(glb_en_o), 0);
          end
          @(negedge clk);
          waits++;
        end
      end
      bus_rdata_valid_i = 1'b0;
      bus_rdata_last_i = 1'b0;
    end
    finish_done("rd");
  endtask

  // mode 0: ready always high, 1: toggling 1/0, 2: random
  task automatic run_write(input logic [31:0] a, input logic [31:0] len,
                           input logic [AW-1:0] g, input int unsigned mode);
    int unsigned nb, idx, sent, cyc, dly;
    bit tog;
    plan(a, len);
    nb = (len + 3) / 4;
    for (int unsigned i = 0; i < nb; i++) gmem[AW'(g + i)] = $urandom;
    send_desc(a, len, g, 1'b1);
    if (nb == 0) begin
      zero_done();
      return;
    end
    idx = 0;
    for (int k = 0; k < ref_beats.size(); k++) begin
      req_phase("wr", ref_addr[k], ref_beats[k], 1'b1);
      sent = 0;
      cyc = 0;
      tog = 1;
      while ((sent < ref_beats[k]) && (cyc < 200)) begin
        case (mode)
          0: bus_wdata_ready_i = 1'b1;
          1: begin bus_wdata_ready_i = tog; tog = ~tog; end
          default: bus_wdata_ready_i = 1'($urandom_range(0, 3) != 0);
        endcase
        #1;
        if (cyc == 0) chk("wr_first_cycle_valid", 32'(bus_wdata_valid_o), 0);
        if (cyc == 1) chk("wr_second_cycle_valid", 32'(bus_wdata_valid_o), 1);
        if ((mode == 0) && (cyc >= 1)) chk("wr_sustained", 32'(bus_wdata_valid_o), 1);
        if (glb_en_o) chk("wr_glb_read", 32'(glb_we_o), 0);
        if (bus_wdata_valid_o) begin
          chk("wr_data", bus_wdata_o, gmem[AW'(g + idx)]);
          chk("wr_strb", 32'(bus_wstrb_o), 32'(ref_strb(len, idx)));
          chk("wr_last", 32'(bus_wlast_o), 32'(sent == ref_beats[k] - 1));
          if (bus_wdata_ready_i) begin
            sent++;
            idx++;
          end
        end
        @(negedge clk);
        cyc++;
      end
      if (sent < ref_beats[k]) chk("wr_beats_timeout", sent, 32'(ref_beats[k]));
      bus_wdata_ready_i = 1'b0;
      dly = $urandom_range(0, 3);
      for (int unsigned i = 0; i < dly; i++) begin
        #1;
        chk("wr_resp_wait_req", 32'(bus_req_valid_o), 0);
        chk("wr_resp_wait_wvalid", 32'(bus_wdata_valid_o), 0);
        chk("wr_resp_wait_irq", 32'(dma_interrupt_o), 0);
        @(negedge clk);
      end
      bus_wresp_valid_i = 1'b1;
      #1;
      chk("wr_resp_busy", 32'(busy_o), 1);
      @(negedge clk);
      bus_wresp_valid_i = 1'b0;
    end
    finish_done("wr");
  endtask

  initial begin
    logic [31:0] ra, rl;
    rst_n = 1'b0;
    desc_valid_i = 1'b0;
    desc_addr_i = '0;
    desc_len_i = '0;
    desc_glb_addr_i = '0;
    desc_dir_i = 1'b0;
    bus_req_ready_i = 1'b0;
    bus_rdata_valid_i = 1'b0;
    bus_rdata_i = '0;
    bus_rdata_last_i = 1'b0;
    bus_wdata_ready_i = 1'b0;
    bus_wresp_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_read(32'h0000_1000, 32'd64, AW'(16'h0010));
    run_read(32'h0000_2000, 32'd6, AW'(16'h0040));
    run_read(32'h0000_0FF8, 32'd40, AW'(16'h0080));
    run_write(32'h0000_4000, 32'd80, AW'(16'h0100), 1);
    run_write(32'h0000_5000, 32'd28, AW'(16'h0200), 0);
    run_write(32'h0000_6FF0, 32'd70, AW'(16'h0300), 2);
    run_read(32'h0000_7000, 32'd0, AW'(16'h0400));
    run_write(32'h0000_7000, 32'd0, AW'(16'h0400), 0);

    // Reset in the middle of a read data phase
    plan(32'h0000_3000, 32'd32);
    send_desc(32'h0000_3000, 32'd32, AW'(16'h0500), 1'b0);
    req_phase("rst_rd", ref_addr[0], ref_beats[0], 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus_rdata_valid_i = 1'b1;
      bus_rdata_i = $urandom;
      #1;
      chk("rst_rd_glb_en", 32'(glb_en_o), 1);
      @(negedge clk);
    end
    bus_rdata_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_idle("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_idle("post_reset");
    @(negedge clk);
    run_read(32'h0000_3000, 32'd8, AW'(16'h0600));

    // Randomized descriptors near page boundaries
    for (int n = 0; n < 12; n++) begin
      ra = 32'($urandom_range(1, 200)) * 4096 + 4096 - 4 * 32'($urandom_range(1, 40))
           + 32'($urandom_range(0, 3));
      rl = 32'($urandom_range(0, 150));
      if ($urandom_range(0, 1) == 0) run_read(ra, rl, AW'($urandom_range(0, 60000)));
      else run_write(ra, rl, AW'($urandom_range(0, 60000)), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
